// File: rtl/command_encoder_if.sv
// command_encoder_if: command-side and SPI-side handshake bundle for command_encoder.
interface command_encoder_if #(
  parameter int INSTRUCTION_WIDTH = 8,
  parameter int ADDRESS_WIDTH = 24,
  parameter int VALUE_WIDTH = 32
);
  logic cmd_valid_i;
  logic cmd_ready_o;
  logic [INSTRUCTION_WIDTH-1:0] cmd_instr_i;
  logic [ADDRESS_WIDTH-1:0] cmd_address_i;
  logic [VALUE_WIDTH-1:0] cmd_value_i;
  logic spi_tx_valid_o;
  logic [7:0] spi_tx_byte_o;
  logic spi_tx_ready_i;
  logic spi_rx_valid_i;
  logic [7:0] spi_rx_byte_i;
  logic rsp_valid_o;
  logic [VALUE_WIDTH-1:0] rsp_data_o;
  logic done_o;
  logic err_o;
  modport slave (
    input cmd_valid_i, cmd_instr_i, cmd_address_i, cmd_value_i, spi_tx_ready_i, spi_rx_valid_i, spi_rx_byte_i,
    output cmd_ready_o, spi_tx_valid_o, spi_tx_byte_o, rsp_valid_o, rsp_data_o, done_o, err_o
  );
  modport master (
    output cmd_valid_i, cmd_instr_i, cmd_address_i, cmd_value_i, spi_tx_ready_i, spi_rx_valid_i, spi_rx_byte_i,
    input cmd_ready_o, spi_tx_valid_o, spi_tx_byte_o, rsp_valid_o, rsp_data_o, done_o, err_o
  );
endinterface

// File: rtl/command_encoder.sv
// command_encoder: serialises opcode/address/value commands into SPI byte frames and collects responses.
module command_encoder #(
  parameter int INSTRUCTION_WIDTH = 8,
  parameter int ADDRESS_WIDTH = 24,
  parameter int VALUE_WIDTH = 32
) (
  input logic clk_i,
  input logic rst_ni,
  command_encoder_if.slave bus
);
  typedef enum logic [1:0] {IDLE, SEND, WAIT_RX, DONE} state_t;
  state_t r_state, w_next;
  logic [INSTRUCTION_WIDTH-1:0] r_instr;
  logic [ADDRESS_WIDTH-1:0] r_addr;
  logic [VALUE_WIDTH-1:0] r_value, r_shift, r_rsp;
  logic [3:0] r_idx;
  logic r_err;
  logic w_accept, w_supported, w_rx, w_last, w_rsp_op;
  logic [3:0] w_len;
  logic [7:0] w_byte;
  logic [23:0] w_a;
  logic [31:0] w_v;
  assign w_accept = bus.cmd_valid_i && r_state == IDLE;
  assign w_supported = bus.cmd_instr_i != '0 && bus.cmd_instr_i <= INSTRUCTION_WIDTH'(8);
  assign w_rx = r_state == WAIT_RX && bus.spi_rx_valid_i;
  assign w_len = r_instr == INSTRUCTION_WIDTH'(1) ? 4'd8 :
                 r_instr == INSTRUCTION_WIDTH'(3) ? 4'd5 :
                 r_instr >= INSTRUCTION_WIDTH'(7) ? 4'd1 : 4'd4;
  assign w_last = r_idx + 4'd1 == w_len;
  assign w_rsp_op = r_instr == INSTRUCTION_WIDTH'(3) || r_instr == INSTRUCTION_WIDTH'(7);
  assign w_a = 24'(r_addr);
  assign w_v = 32'(r_value);
  // STREAM carries value bytes from index 1; WRITE carries address at 1..3 then value at 4..7
  assign w_byte = r_idx == 4'd0 ? 8'(r_instr) :
                  r_instr == INSTRUCTION_WIDTH'(3) ? w_v[8*(4-r_idx) +: 8] :
                  r_idx < 4'd4 ? w_a[8*(3-r_idx) +: 8] : w_v[8*(7-r_idx) +: 8];
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) r_state <= IDLE;
    else r_state <= w_next;
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: w_next = w_accept && w_supported ? SEND : IDLE;
      SEND: w_next = bus.spi_tx_ready_i ? WAIT_RX : SEND;
      WAIT_RX: w_next = bus.spi_rx_valid_i ? (w_last ? DONE : SEND) : WAIT_RX;
      default: w_next = IDLE;
    endcase
  end
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      r_instr <= '0;
      r_addr <= '0;
      r_value <= '0;
      r_shift <= '0;
      r_rsp <= '0;
      r_idx <= '0;
      r_err <= 1'b0;
    end else begin
      r_err <= w_accept && !w_supported;
      if (w_accept) begin
        r_instr <= bus.cmd_instr_i;
        r_addr <= bus.cmd_address_i;
        r_value <= bus.cmd_value_i;
        r_shift <= '0;
        r_idx <= '0;
      end
      // the shift register keeps only the last four rx bytes, which is exactly the STREAM payload
      if (w_rx) begin
        r_idx <= r_idx + 4'd1;
        r_shift <= {r_shift[VALUE_WIDTH-9:0], bus.spi_rx_byte_i};
        if (w_last && w_rsp_op) r_rsp <= {r_shift[VALUE_WIDTH-9:0], bus.spi_rx_byte_i};
      end
    end
  assign bus.cmd_ready_o = r_state == IDLE;
  assign bus.spi_tx_valid_o = r_state == SEND;
  assign bus.spi_tx_byte_o = r_state == SEND ? w_byte : 8'h00;
  assign bus.done_o = r_state == DONE;
  assign bus.rsp_valid_o = r_state == DONE && w_rsp_op;
  assign bus.rsp_data_o = r_rsp;
  assign bus.err_o = r_err;
endmodule
